// File: rtl/sram_ctrl_pkg.sv
// Shared widths and FSM state encoding for the external 256K x 16 SRAM controller.
package sram_ctrl_pkg;

  localparam int SRAM_ADDR_W = 18;
  localparam int SRAM_DATA_W = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    DRAIN = 2'd3
  } sram_ctrl_state_t;

endpackage

// File: rtl/sram_read_pipe.sv
// Fixed-latency read return path: stage 1 captures the SRAM bus one edge after the
// address is registered, later stages delay word and valid up to READ_LATENCY.
module sram_read_pipe
  import sram_ctrl_pkg::*;
#(
  parameter int READ_LATENCY = 2
) (
  input  logic                   Clock_50,
  input  logic                   clear,
  input  logic                   issue,
  input  logic [SRAM_DATA_W-1:0] bus_data,
  output logic [SRAM_DATA_W-1:0] rdata,
  output logic                   rdata_valid,
  output logic                   in_flight
);

  logic [READ_LATENCY:0]  vld;
  logic [SRAM_DATA_W-1:0] dat [1:READ_LATENCY];

  always_ff @(posedge Clock_50) begin
    if (clear) begin
      vld <= '0;
      for (int i = 1; i <= READ_LATENCY; i++) dat[i] <= '0;
    end else begin
      vld    <= {vld[READ_LATENCY-1:0], issue};
      dat[1] <= bus_data;
      for (int i = 2; i <= READ_LATENCY; i++) dat[i] <= dat[i-1];
    end
  end

  assign rdata       = dat[READ_LATENCY];
  assign rdata_valid = vld[READ_LATENCY];
  // The last stage is excluded so the FSM reaches IDLE on the same edge the final word emerges.
  assign in_flight   = |vld[READ_LATENCY-2:0];

endmodule

// File: rtl/sram_access_controller.sv
// Turns client burst requests into registered SRAM pin activity, one word per Clock_50.
//   state | meaning
//   IDLE  | ready for a request, strobes parked (CE/OE/UB/LB active, WE inactive)
//   READ  | issuing one read address per cycle into the return pipe
//   WRITE | issuing one write per cycle that wdata_valid is high, stalling otherwise
//   DRAIN | read addresses done, waiting for the return pipe to empty
module sram_access_controller
  import sram_ctrl_pkg::*;
#(
  parameter int READ_LATENCY = 2,
  parameter int LEN_W        = 8
) (
  input  logic                   Clock_50,
  input  logic                   Reset,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic                   req_we,
  input  logic [SRAM_ADDR_W-1:0] req_addr,
  input  logic [LEN_W-1:0]       req_len,
  input  logic [SRAM_DATA_W-1:0] wdata,
  input  logic                   wdata_valid,
  output logic                   wdata_ready,
  output logic [SRAM_DATA_W-1:0] rdata,
  output logic                   rdata_valid,
  output logic                   busy,
  inout  wire  [SRAM_DATA_W-1:0] SRAM_data_io,
  output logic [SRAM_ADDR_W-1:0] SRAM_address,
  output logic                   SRAM_UB_N,
  output logic                   SRAM_LB_N,
  output logic                   SRAM_WE_N,
  output logic                   SRAM_CE_N,
  output logic                   SRAM_OE_N
);

  sram_ctrl_state_t       state;
  logic [SRAM_ADDR_W-1:0] addr;
  logic [LEN_W-1:0]       count;
  logic [SRAM_DATA_W-1:0] wdata_q;
  logic                   in_flight;

  always_ff @(posedge Clock_50) begin
    if (Reset) begin
      state        <= IDLE;
      addr         <= '0;
      count        <= '0;
      wdata_q      <= '0;
      req_ready    <= 1'b0;
      wdata_ready  <= 1'b0;
      SRAM_address <= '0;
      SRAM_WE_N    <= 1'b1;
      SRAM_CE_N    <= 1'b1;
      SRAM_OE_N    <= 1'b1;
      SRAM_UB_N    <= 1'b1;
      SRAM_LB_N    <= 1'b1;
    end else begin
      SRAM_CE_N <= 1'b0;
      SRAM_OE_N <= 1'b0;
      SRAM_UB_N <= 1'b0;
      SRAM_LB_N <= 1'b0;
      SRAM_WE_N <= 1'b1;
      case (state)
        IDLE: begin
          req_ready <= 1'b1;
          if (req_valid && req_ready) begin
            addr      <= req_addr;
            count     <= req_len;
            req_ready <= 1'b0;
            if (req_we) begin
              state       <= WRITE;
              wdata_ready <= 1'b1;
            end else begin
              state <= READ;
            end
          end
        end
        READ: begin
          SRAM_address <= addr;
          addr         <= addr + SRAM_ADDR_W'(1);
          count        <= count - LEN_W'(1);
          if (count == '0) state <= DRAIN;
        end
        WRITE: begin
          // A stall leaves address, count and the bus (WE_N high) untouched.
          if (wdata_valid) begin
            SRAM_address <= addr;
            wdata_q      <= wdata;
            SRAM_WE_N    <= 1'b0;
            addr         <= addr + SRAM_ADDR_W'(1);
            count        <= count - LEN_W'(1);
            if (count == '0) begin
              state       <= IDLE;
              wdata_ready <= 1'b0;
              req_ready   <= 1'b1;
            end
          end
        end
        DRAIN: begin
          if (!in_flight) begin
            state     <= IDLE;
            req_ready <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign busy = (state != IDLE);

  // Drive only while the registered write strobe is active so device read data never collides.
  assign SRAM_data_io = !SRAM_WE_N ? wdata_q : {SRAM_DATA_W{1'bz}};

  sram_read_pipe #(
    .READ_LATENCY(READ_LATENCY)
  ) u_read_pipe (
    .Clock_50   (Clock_50),
    .clear      (Reset),
    .issue      (state == READ),
    .bus_data   (SRAM_data_io),
    .rdata      (rdata),
    .rdata_valid(rdata_valid),
    .in_flight  (in_flight)
  );

endmodule

// File: tb/tb_sram_access_controller.sv
// Directed bench for sram_access_controller with a behavioural asynchronous SRAM model.
module tb_sram_access_controller;

  localparam int RL = 2;

  typedef struct {
    bit          we;
    logic [17:0] addr;
    logic [7:0]  len;
    logic [15:0] d0;
    logic [15:0] step;
    logic [15:0] vpat;
    logic [15:0] exp_d0;
    logic [15:0] exp_step;
  } vec_t;

  logic        Clock_50;
  logic        Reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [17:0] req_addr;
  logic [7:0]  req_len;
  logic [15:0] wdata;
  logic        wdata_valid;
  logic        wdata_ready;
  logic [15:0] rdata;
  logic        rdata_valid;
  logic        busy;
  wire  [15:0] SRAM_data_io;
  logic [17:0] SRAM_address;
  logic        SRAM_UB_N, SRAM_LB_N, SRAM_WE_N, SRAM_CE_N, SRAM_OE_N;

  logic [15:0] mem [0:262143];
  int n_pass  = 0;
  int n_total = 0;

  sram_access_controller #(.READ_LATENCY(RL), .LEN_W(8)) dut (
    .Clock_50    (Clock_50),
    .Reset       (Reset),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_we      (req_we),
    .req_addr    (req_addr),
    .req_len     (req_len),
    .wdata       (wdata),
    .wdata_valid (wdata_valid),
    .wdata_ready (wdata_ready),
    .rdata       (rdata),
    .rdata_valid (rdata_valid),
    .busy        (busy),
    .SRAM_data_io(SRAM_data_io),
    .SRAM_address(SRAM_address),
    .SRAM_UB_N   (SRAM_UB_N),
    .SRAM_LB_N   (SRAM_LB_N),
    .SRAM_WE_N   (SRAM_WE_N),
    .SRAM_CE_N   (SRAM_CE_N),
    .SRAM_OE_N   (SRAM_OE_N)
  );

  initial Clock_50 = 1'b0;
  always #10 Clock_50 = ~Clock_50;

  // Asynchronous-read SRAM: drives while selected and not writing, latches writes at the edge.
  assign SRAM_data_io = (!SRAM_CE_N && !SRAM_OE_N && SRAM_WE_N) ? mem[SRAM_address] : 16'hzzzz;
  always @(posedge Clock_50)
    if (!SRAM_CE_N && !SRAM_WE_N) mem[SRAM_address] <= SRAM_data_io;

  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge Clock_50);
    #1;
  endtask

  task automatic wait_ready();
    int k = 0;
    while (req_ready !== 1'b1 && k < 50) begin
      tick();
      k++;
    end
    if (k >= 50) check("req_ready_timeout", int'(req_ready), 1);
  endtask

  task automatic request(input bit we, input logic [17:0] a, input logic [7:0] len);
    wait_ready();
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = a;
    req_len   = len;
    tick();
    req_valid = 1'b0;
  endtask

  task automatic run_write(input vec_t v);
    int sent = 0, c = 0, lows = 0, we_err = 0, adr_err = 0, rdy_err = 0, mem_err = 0;
    bit pend, have = 0;
    logic [17:0] last = '0;
    logic [17:0] a;
    request(1'b1, v.addr, v.len);
    while (sent <= int'(v.len) && c < 600) begin
      if (wdata_ready !== 1'b1) rdy_err++;
      pend        = (c < 16) ? v.vpat[c] : 1'b1;
      wdata_valid = pend;
      wdata       = 16'(v.d0 + v.step * sent);
      tick();
      c++;
      if (int'(SRAM_WE_N) != (pend ? 0 : 1)) we_err++;
      if (pend) begin
        last = 18'(v.addr + 18'(sent));
        have = 1;
        sent++;
      end
      if (have && SRAM_address !== last) adr_err++;
      if (!SRAM_WE_N) lows++;
    end
    wdata_valid = 1'b0;
    check("wr_wdata_ready", rdy_err, 0);
    check("wr_we_n_pattern", we_err, 0);
    check("wr_address", adr_err, 0);
    check("wr_we_low_count", lows, int'(v.len) + 1);
    check("wr_idle_flags", int'({busy, req_ready, wdata_ready}), 3'b010);
    tick();
    check("wr_we_n_released", int'(SRAM_WE_N), 1);
    for (int i = 0; i <= int'(v.len); i++) begin
      a = 18'(v.addr + 18'(i));
      if (mem[a] !== 16'(v.exp_d0 + v.exp_step * i)) mem_err++;
    end
    check("wr_mem_contents", mem_err, 0);
  endtask

  task automatic run_read(input vec_t v);
    int n = int'(v.len) + 1;
    int adr_err = 0, we_err = 0, vld_err = 0, dat_err = 0, busy_err = 0, strobes = 0;
    bit exp_v;
    request(1'b0, v.addr, v.len);
    for (int c = 1; c <= n + RL + 1; c++) begin
      tick();
      if (c <= n) begin
        if (SRAM_address !== 18'(v.addr + 18'(c - 1))) adr_err++;
        if (SRAM_WE_N !== 1'b1) we_err++;
      end
      exp_v = (c >= 1 + RL) && (c <= n + RL);
      if (rdata_valid !== exp_v) vld_err++;
      if (rdata_valid === 1'b1) begin
        strobes++;
        if (rdata !== 16'(v.exp_d0 + v.exp_step * (c - 1 - RL))) dat_err++;
      end
      if (busy !== (c < n + RL)) busy_err++;
    end
    check("rd_address", adr_err, 0);
    check("rd_we_n_high", we_err, 0);
    check("rd_valid_timing", vld_err, 0);
    check("rd_data", dat_err, 0);
    check("rd_strobe_count", strobes, n);
    check("rd_busy_window", busy_err, 0);
    check("rd_ready_after", int'(req_ready), 1);
  endtask

  vec_t tbl [9];

  initial begin
    int strobes;
    tbl[0] = '{1'b1, 18'h00010, 8'd3,   16'hA000, 16'h0001, 16'hFFFF, 16'hA000, 16'h0001};
    tbl[1] = '{1'b0, 18'h00010, 8'd3,   16'h0000, 16'h0000, 16'h0000, 16'hA000, 16'h0001};
    tbl[2] = '{1'b1, 18'h00020, 8'd1,   16'hBEEF, 16'h0101, 16'h0009, 16'hBEEF, 16'h0101};
    tbl[3] = '{1'b0, 18'h00020, 8'd1,   16'h0000, 16'h0000, 16'h0000, 16'hBEEF, 16'h0101};
    tbl[4] = '{1'b1, 18'h3FFFF, 8'd1,   16'h1111, 16'h1111, 16'hFFFF, 16'h1111, 16'h1111};
    tbl[5] = '{1'b0, 18'h3FFFF, 8'd1,   16'h0000, 16'h0000, 16'h0000, 16'h1111, 16'h1111};
    tbl[6] = '{1'b1, 18'h00005, 8'd0,   16'h7777, 16'h0000, 16'hFFFF, 16'h7777, 16'h0000};
    tbl[7] = '{1'b0, 18'h00005, 8'd0,   16'h0000, 16'h0000, 16'h0000, 16'h7777, 16'h0000};
    tbl[8] = '{1'b0, 18'h00100, 8'd255, 16'h0000, 16'h0000, 16'h0000, 16'h0007, 16'h0003};

    for (int i = 0; i < 256; i++) mem[18'h00100 + 18'(i)] = 16'(16'h0007 + 3 * i);

    Reset       = 1'b1;
    req_valid   = 1'b0;
    req_we      = 1'b0;
    req_addr    = '0;
    req_len     = '0;
    wdata       = '0;
    wdata_valid = 1'b0;
    repeat (3) tick();
    check("rst_strobes", int'({SRAM_CE_N, SRAM_OE_N, SRAM_UB_N, SRAM_LB_N, SRAM_WE_N}), 5'h1F);
    check("rst_address", int'(SRAM_address), 0);
    check("rst_flags", int'({req_ready, wdata_ready, busy, rdata_valid}), 0);
    check("rst_rdata", int'(rdata), 0);
    Reset = 1'b0;
    tick();
    check("post_rst_ready", int'(req_ready), 1);
    check("post_rst_strobes", int'({SRAM_CE_N, SRAM_OE_N, SRAM_UB_N, SRAM_LB_N, SRAM_WE_N}), 5'h01);
    wdata_valid = 1'b1;
    tick();
    check("idle_ignores_wdata", int'({SRAM_WE_N, busy, rdata_valid}), 3'b100);
    wdata_valid = 1'b0;

    for (int i = 0; i < 9; i++) begin
      if (tbl[i].we) run_write(tbl[i]);
      else           run_read(tbl[i]);
    end
    check("wrap_mem_top", int'(mem[18'h3FFFF]), 16'h1111);
    check("wrap_mem_zero", int'(mem[18'h00000]), 16'h2222);

    // Reset lands after the fifth read address of a 16-word burst.
    request(1'b0, 18'h00040, 8'd15);
    repeat (5) tick();
    check("mid_rst_addr5", int'(SRAM_address), 18'h00044);
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    check("mid_rst_strobes", int'({SRAM_CE_N, SRAM_OE_N, SRAM_UB_N, SRAM_LB_N, SRAM_WE_N}), 5'h1F);
    check("mid_rst_flags", int'({req_ready, busy, rdata_valid}), 0);
    check("mid_rst_address", int'(SRAM_address), 0);
    strobes = 0;
    repeat (6) begin
      tick();
      if (rdata_valid === 1'b1) strobes++;
    end
    check("mid_rst_no_valid", strobes, 0);
    run_read(tbl[1]);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/sram_access_controller.md
Name: sram_access_controller

Overview:
Initiator-side controller for the external 256K x 16 SRAM: turns client burst read/write requests into cycle-accurate SRAM pin activity (address, CE_N/OE_N/WE_N/UB_N/LB_N, tri-stated data bus).
Sits between the decompressor datapath (milestone FSMs) and the top-level SRAM pins; in simulation it drives the SRAM emulator directly.
One word transferred per Clock_50 cycle; a bounded read pipeline returns data at fixed latency.

Parameters:
READ_LATENCY, 2, cycles from address-registered edge to rdata/rdata_valid registered edge (>=2)
LEN_W, 8, width of burst length field; burst = req_len+1 words

Ports:
Clock_50  input  1  sole clock, all logic on posedge
Reset  input  1  synchronous, active-high reset
req_valid  input  1  client burst request valid
req_ready  output  1  controller idle, request accepted when req_valid&req_ready
req_we  input  1  1=write burst, 0=read burst
req_addr  input  18  start word address
req_len  input  LEN_W  words minus one
wdata  input  16  write word
wdata_valid  input  1  write word available
wdata_ready  output  1  write word consumed this cycle when wdata_valid&wdata_ready
rdata  output  16  read word
rdata_valid  output  1  one-cycle strobe per read word, no back-pressure
busy  output  1  high in any non-IDLE state
SRAM_data_io  inout  16  bidirectional bus, driven only while SRAM_WE_N=0
SRAM_address  output  18  registered address
SRAM_UB_N, SRAM_LB_N  output  1 each  byte enables
SRAM_WE_N, SRAM_CE_N, SRAM_OE_N  output  1 each  strobes

Behaviour:
- All SRAM outputs registered. Reset (sync, high, also mid-burst): state=IDLE, SRAM_address=0, WE_N=1, CE_N=1, OE_N=1, UB_N=1, LB_N=1, SRAM_data_io high-Z, rdata=0, rdata_valid=0, read pipeline valids cleared (no rdata_valid after reset), req_ready=0 in reset cycle then 1, wdata_ready=0, busy=0.
- States: IDLE, READ, WRITE, DRAIN.
- IDLE: req_ready=1; CE_N=OE_N=UB_N=LB_N=0 after first post-reset cycle, WE_N=1. On req_valid: latch addr, count=req_len; go READ or WRITE. wdata_valid ignored in IDLE.
- READ: each cycle register SRAM_address=addr, WE_N=1, push valid into READ_LATENCY-deep pipe; addr+=1, count-=1; after word count 0 -> DRAIN. Bus sampled at edge k+1 for address registered at edge k; rdata/rdata_valid registered at edge k+READ_LATENCY.
- DRAIN: WE_N=1, wait until pipe empty (READ_LATENCY-1 cycles after last issue), then IDLE. req_ready=0 until IDLE.
- WRITE: wdata_ready=1. Cycle with wdata_valid: register SRAM_address=addr, data out reg=wdata, WE_N=0; addr+=1, count-=1; last word -> IDLE next edge (WE_N=1 there). Cycle without wdata_valid: stall, WE_N=1, address held, bus high-Z, count unchanged.
- Bus drive enable = registered ~WE_N; never drive while WE_N=1 (prevents contention with device read data).
- Address arithmetic mod 2^18: 18'h3FFFF+1 -> 0, burst continues.
- req_len=255 -> 256 words; req_len=0 -> single word.
- Back-to-back: new request accepted only in IDLE; minimum gap one IDLE cycle.

Decomposition:
- Package sram_ctrl_pkg: SRAM_ADDR_W=18, SRAM_DATA_W=16, state enum sram_ctrl_state_t {IDLE,READ,WRITE,DRAIN}.
- Sub-module sram_read_pipe: READ_LATENCY-stage valid/data shift register with sync clear; capture stage fed from SRAM_data_io.

Test Plan:
- Reset then idle -> all strobes/enables =1 during reset, bus Z, req_ready=1 next cycle, no rdata_valid.
- Write burst addr=0x00010, len=3, wdata 0xA000..0xA003 continuous -> WE_N=0 four consecutive cycles, emulator words 0x10..0x13 hold 0xA000..0xA003; read back len=3 -> rdata_valid exactly 2 cycles after each address, values match in order.
- Write stall: wdata_valid pattern 1,0,0,1 for len=1 -> WE_N low only in cycles 1 and 4, address 0x00020 then 0x00021, bus Z during stall.
- Wrap: write 2 words at 0x3FFFF (0x1111,0x2222) -> mem[0x3FFFF]=0x1111, mem[0x00000]=0x2222; read burst confirms.
- Reset asserted mid read burst (len=15, after 5 addresses) -> rdata_valid never asserts after reset edge, outputs return to reset values, next request works.
- Max burst len=255 read of known pattern -> exactly 256 rdata_valid strobes, busy drops 2 cycles after last address.
